tdm_demux_eight: RTL and testbench
==================================

Name: tdm_demux_eight

Overview:
Receive-side counterpart of the team's 8-channel TDM serial link. The transmitter serialises eight 1-bit channels through an 8:1 select driven by a 3-bit slot count. This block runs the slot count on the receive side and steers each incoming bit to its channel. It aligns to a frame-sync marker and presents the eight channels as a parallel word with a one-cycle valid pulse.

Parameters:
SEL_W, 3, slot-index width; channel count = 2**SEL_W. Only 3 is verified.
MISS_LIMIT, 2, consecutive missing fsync markers tolerated before losing lock. Used only with FLYWHEEL_EN.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
din  input  1  serial TDM data bit
din_valid  input  1  din/fsync sampled only when 1
fsync  input  1  marks the channel-0 bit of a frame; qualified by din_valid
y  output  8  last complete frame; bit k = channel k
frame_valid  output  1  one-cycle pulse when y updates
ch_sel  output  3  slot the next valid bit is stored to
locked  output  1  1 while in RUN
sync_err  output  1  one-cycle pulse on a framing violation

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - y=0, frame_valid=0, sync_err=0, locked=0, ch_sel=0
  - shadow register=0, state=HUNT
  - Reset mid-frame discards the partial frame; no frame_valid is issued.
- States: HUNT (0), RUN (1). locked = (state==RUN). Only edges with din_valid=1 advance anything.
- HUNT:
  - ch_sel=0.
  - Bits without fsync are ignored.
  - On din_valid & fsync: shadow[0]<=din, slot<=1, go to RUN.
- RUN, din_valid=1, fsync=0, slot in 1..6: shadow[slot]<=din, slot<=slot+1.
- RUN, slot==7, din_valid=1, fsync=0: at that same edge
  - y <= {din, shadow[6:0]}
  - frame_valid<=1 for exactly one cycle
  - slot wraps to 0
- RUN, slot==0, din_valid=1:
  - fsync=1: shadow[0]<=din, slot<=1. Back-to-back frames run with no idle cycle; frame_valid may pulse every 8 valid cycles.
  - fsync=0 (missing marker): sync_err pulses, state<=HUNT, bit discarded.
- RUN, slot in 1..7, din_valid & fsync (early marker):
  - sync_err pulses; partial frame discarded; y unchanged; no frame_valid.
  - Resync: this bit is treated as channel 0, so shadow[0]<=din, slot<=1, stay in RUN.
- din_valid=0: all state, slot and shadow hold; frame_valid and sync_err are 0.
- Latency: y is valid and frame_valid=1 in the cycle after the edge that samples the channel-7 bit.
- ch_sel = slot in RUN and 0 in HUNT. It is registered and glitch-free.
- y holds its value between frames and across a loss of lock.

Optional Feature:
Macro: TDM_DEMUX_FLYWHEEL_EN.
- Defined:
  - A missing marker at slot 0 in RUN pulses sync_err but stays in RUN; the bit is stored as channel 0 (flywheel).
  - A saturating miss counter increments on each miss; a correctly marked frame start clears it to 0.
  - HUNT is entered only when the counter reaches MISS_LIMIT.
- Undefined: a single missing marker goes to HUNT, as specified above. No miss counter is synthesised.

Decomposition:
- Shared package/header tdm_pkg: SEL_W, NUM_CH=8, state encodings ST_HUNT=1'b0 and ST_RUN=1'b1, MISS_LIMIT default.
- Transmitter and receiver both include the same package.
- One sub-module: tdm_slot_counter, a 3-bit counter with sync clear, load-to-1 and increment-with-wrap, reused by the transmitter.
- Shadow register, FSM and output register stay in the top.

Test Plan:
- Reset, then frame 8'hA5 sent ch0→ch7 (bits 1,0,1,0,0,1,0,1), fsync on the first bit:
  - y=8'hA5, frame_valid high exactly one cycle after the eighth bit, locked=1.
- Two back-to-back frames 8'h3C then 8'hC3, no idle cycles: two frame_valid pulses 8 cycles apart, y=8'h3C then 8'hC3.
- Frame 8'hFF with din_valid low for 3 cycles between bits 4 and 5: y=8'hFF, ch_sel holds 5 during the gap.
- fsync asserted at slot 4, then a clean frame 8'h81 from that bit:
  - sync_err pulses once, no frame_valid for the broken frame, y=8'h81 afterwards.
- Missing fsync at slot 0 after a good frame:
  - Without the macro: sync_err=1, locked=0, y keeps its old value.
  - With the macro: locked stays 1 until MISS_LIMIT=2 consecutive misses.
- rst asserted after 5 bits of a frame, then a clean frame 8'h5A: y=0 and locked=0 after the reset; y=8'h5A and a single frame_valid afterwards.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared definitions for the 8-channel TDM link (transmit and receive sides).
package tdm_pkg;

  localparam int SEL_W          = 3;
  localparam int NUM_CH         = 1 << SEL_W;
  localparam int MISS_LIMIT_DEF = 2;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_RUN  = 1'b1
  } tdm_state_e;

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index counter: synchronous clear, load-to-1 and increment with natural wrap.
module tdm_slot_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         load1_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load1_i) begin
      cnt_d = W'(1);
    end else if (inc_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/tdm_demux_eight.sv
// TDM receive demultiplexer: aligns to fsync, steers bits to channels, emits parallel frames.
// Optional flywheel tolerance of missing markers: define TDM_DEMUX_FLYWHEEL_EN.
module tdm_demux_eight
  import tdm_pkg::*;
#(
  parameter int SEL_W      = tdm_pkg::SEL_W,
  parameter int MISS_LIMIT = MISS_LIMIT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    din,
  input  logic                    din_valid,
  input  logic                    fsync,
  output logic [(1<<SEL_W)-1:0]   y,
  output logic                    frame_valid,
  output logic [SEL_W-1:0]        ch_sel,
  output logic                    locked,
  output logic                    sync_err
);

  localparam int NCH = 1 << SEL_W;
  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(NCH - 1);

  if (MISS_LIMIT < 1 || SEL_W < 1) begin : g_param_check
    $error("tdm_demux_eight: MISS_LIMIT and SEL_W must be at least 1");
  end

  tdm_state_e        state_q, state_d;
  logic [SEL_W-1:0]  slot_q;
  logic              slot_clr, slot_load1, slot_inc;
  logic              shadow_wr;
  logic [SEL_W-1:0]  shadow_idx;
  logic [NCH-2:0]    shadow_q;
  logic [NCH-1:0]    y_q;
  logic              y_we;
  logic              fv_q, fv_d;
  logic              se_q, se_d;

`ifdef TDM_DEMUX_FLYWHEEL_EN
  localparam int MISS_W = $clog2(MISS_LIMIT + 1);
  logic [MISS_W-1:0] miss_q;
  logic              miss_clr, miss_inc;
`endif

  tdm_slot_counter #(.W(SEL_W)) u_slot (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (slot_clr),
    .load1_i (slot_load1),
    .inc_i   (slot_inc),
    .cnt_o   (slot_q)
  );

  always_comb begin
    state_d    = state_q;
    slot_clr   = 1'b0;
    slot_load1 = 1'b0;
    slot_inc   = 1'b0;
    shadow_wr  = 1'b0;
    shadow_idx = '0;
    y_we       = 1'b0;
    fv_d       = 1'b0;
    se_d       = 1'b0;
`ifdef TDM_DEMUX_FLYWHEEL_EN
    miss_clr   = 1'b0;
    miss_inc   = 1'b0;
`endif
    if (din_valid) begin
      unique case (state_q)
        ST_HUNT: begin
          if (fsync) begin
            shadow_wr  = 1'b1;
            slot_load1 = 1'b1;
            state_d    = ST_RUN;
`ifdef TDM_DEMUX_FLYWHEEL_EN
            miss_clr   = 1'b1;
`endif
          end
        end
        ST_RUN: begin
          if (fsync) begin
            // A marker anywhere restarts the frame at channel 0; only off-slot-0 is an error.
            se_d       = (slot_q != '0);
            shadow_wr  = 1'b1;
            slot_load1 = 1'b1;
`ifdef TDM_DEMUX_FLYWHEEL_EN
            miss_clr   = (slot_q == '0);
`endif
          end else if (slot_q == '0) begin
            se_d = 1'b1;
`ifdef TDM_DEMUX_FLYWHEEL_EN
            miss_inc = 1'b1;
            if (int'(miss_q) + 1 >= MISS_LIMIT) begin
              state_d  = ST_HUNT;
              slot_clr = 1'b1;
            end else begin
              shadow_wr  = 1'b1;
              slot_load1 = 1'b1;
            end
`else
            state_d  = ST_HUNT;
            slot_clr = 1'b1;
`endif
          end else if (slot_q == LAST_SLOT) begin
            y_we     = 1'b1;
            fv_d     = 1'b1;
            slot_inc = 1'b1;
          end else begin
            shadow_wr  = 1'b1;
            shadow_idx = slot_q;
            slot_inc   = 1'b1;
          end
        end
        default: begin
          state_d  = ST_HUNT;
          slot_clr = 1'b1;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH - 1; gi++) begin : g_shadow
      always_ff @(posedge clk) begin
        if (rst) begin
          shadow_q[gi] <= 1'b0;
        end else if (shadow_wr && (shadow_idx == SEL_W'(gi))) begin
          shadow_q[gi] <= din;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HUNT;
      y_q     <= '0;
      fv_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fv_q    <= fv_d;
      se_q    <= se_d;
      // The channel-7 bit goes straight to y so the frame is out one cycle after it arrives.
      if (y_we) begin
        y_q <= {din, shadow_q};
      end
    end
  end

`ifdef TDM_DEMUX_FLYWHEEL_EN
  always_ff @(posedge clk) begin
    if (rst || miss_clr) begin
      miss_q <= '0;
    end else if (miss_inc && (int'(miss_q) < MISS_LIMIT)) begin
      miss_q <= miss_q + MISS_W'(1);
    end
  end
`endif

  assign y           = y_q;
  assign frame_valid = fv_q;
  assign sync_err    = se_q;
  assign locked      = (state_q == ST_RUN);
  assign ch_sel      = slot_q;

endmodule

// File: tb/tb_tdm_demux_eight.sv
// Self-checking bench for tdm_demux_eight: directed test plan then random traffic vs a queue model.
module tb_tdm_demux_eight;

  localparam int MISS_LIMIT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       fsync = 1'b0;
  logic [7:0] y;
  logic       frame_valid;
  logic [2:0] ch_sel;
  logic       locked;
  logic       sync_err;

  int checks = 0;
  int errors = 0;

  // Reference model: received bits of the current frame kept in a queue.
  bit         m_q[$];
  bit         m_locked = 1'b0;
  logic [7:0] m_y = 8'h00;
  bit         m_fv = 1'b0;
  bit         m_se = 1'b0;
  int         m_miss = 0;

  tdm_demux_eight dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .fsync       (fsync),
    .y           (y),
    .frame_valid (frame_valid),
    .ch_sel      (ch_sel),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit d, input bit v, input bit f, input bit r);
    m_fv = 1'b0;
    m_se = 1'b0;
    if (r) begin
      m_q.delete();
      m_locked = 1'b0;
      m_y = 8'h00;
      m_miss = 0;
    end else if (v) begin
      if (!m_locked) begin
        if (f) begin
          m_q.delete();
          m_q.push_back(d);
          m_locked = 1'b1;
          m_miss = 0;
        end
      end else if (f) begin
        if (m_q.size() != 0) m_se = 1'b1;
        else m_miss = 0;
        m_q.delete();
        m_q.push_back(d);
      end else if (m_q.size() == 0) begin
        m_se = 1'b1;
`ifdef TDM_DEMUX_FLYWHEEL_EN
        m_miss++;
        if (m_miss >= MISS_LIMIT) m_locked = 1'b0;
        else m_q.push_back(d);
`else
        m_locked = 1'b0;
`endif
      end else begin
        m_q.push_back(d);
        if (m_q.size() == 8) begin
          for (int k = 0; k < 8; k++) m_y[k] = m_q[k];
          m_fv = 1'b1;
          m_q.delete();
        end
      end
    end
  endtask

  task automatic cycle(input bit d, input bit v, input bit f, input bit r);
    int exp_sel;
    din = d; din_valid = v; fsync = f; rst = r;
    @(posedge clk);
    model_step(d, v, f, r);
    #1;
    exp_sel = m_locked ? m_q.size() : 0;
    chk("y", y, m_y);
    chk("frame_valid", {7'b0, frame_valid}, {7'b0, m_fv});
    chk("sync_err", {7'b0, sync_err}, {7'b0, m_se});
    chk("locked", {7'b0, locked}, {7'b0, m_locked});
    chk("ch_sel", {5'b0, ch_sel}, 8'(exp_sel));
    if (frame_valid) $display("frame y=%h t=%0t", y, $time);
  endtask

  task automatic send_bits(input logic [7:0] v, input int first, input int last, input bit mark);
    for (int i = first; i <= last; i++) cycle(v[i], 1'b1, mark && (i == first), 1'b0);
  endtask

  initial begin
    bit rd, rv, rf, rr;

    // Reset state
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_y", y, 8'h00);
    chk("rst_locked", {7'b0, locked}, 8'h00);

    // Single frame A5
    send_bits(8'hA5, 0, 7, 1'b1);
    chk("a5_y", y, 8'hA5);
    chk("a5_fv", {7'b0, frame_valid}, 8'h01);
    chk("a5_locked", {7'b0, locked}, 8'h01);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("a5_fv_one_cycle", {7'b0, frame_valid}, 8'h00);

    // Back-to-back frames
    send_bits(8'h3C, 0, 7, 1'b1);
    chk("b2b_y0", y, 8'h3C);
    send_bits(8'hC3, 0, 7, 1'b1);
    chk("b2b_y1", y, 8'hC3);
    chk("b2b_fv1", {7'b0, frame_valid}, 8'h01);

    // Gap of three invalid cycles after five bits
    send_bits(8'hFF, 0, 4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      chk("gap_ch_sel", {5'b0, ch_sel}, 8'd5);
    end
    send_bits(8'hFF, 5, 7, 1'b0);
    chk("gap_y", y, 8'hFF);

    // Early marker at slot 4, resync into frame 81
    send_bits(8'h0F, 0, 3, 1'b1);
    chk("early_pre_sel", {5'b0, ch_sel}, 8'd4);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    chk("early_se", {7'b0, sync_err}, 8'h01);
    chk("early_y_held", y, 8'hFF);
    send_bits(8'h81, 1, 7, 1'b0);
    chk("early_y", y, 8'h81);

    // Missing marker at slot 0
    send_bits(8'h66, 0, 7, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    chk("miss_se", {7'b0, sync_err}, 8'h01);
    chk("miss_y_held", y, 8'h66);
`ifdef TDM_DEMUX_FLYWHEEL_EN
    chk("miss1_locked", {7'b0, locked}, 8'h01);
    send_bits(8'h00, 1, 7, 1'b0);
    chk("fly_y", y, 8'h01);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("miss2_locked", {7'b0, locked}, 8'h00);
`else
    chk("miss_locked", {7'b0, locked}, 8'h00);
`endif

    // Reset in the middle of a frame
    send_bits(8'h1F, 0, 4, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    chk("midrst_y", y, 8'h00);
    chk("midrst_locked", {7'b0, locked}, 8'h00);
    send_bits(8'h5A, 0, 7, 1'b1);
    chk("midrst_frame_y", y, 8'h5A);
    chk("midrst_frame_fv", {7'b0, frame_valid}, 8'h01);

    // Random traffic with mostly well-placed markers
    for (int i = 0; i < 1500; i++) begin
      rv = ($urandom_range(0, 9) != 0);
      rr = ($urandom_range(0, 399) == 0);
      rd = 1'($urandom_range(0, 1));
      if (m_locked && m_q.size() != 0) rf = ($urandom_range(0, 29) == 0);
      else rf = ($urandom_range(0, 7) != 0);
      cycle(rd, rv, rf, rr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
